// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared constants and frame-layout helpers for led_scan_driver
package led_scan_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_SEGS       = 7;
    localparam int DEF_LEDS       = 7;
    localparam int DEF_FIELD_W    = 8;
    localparam int DEF_BRIGHT_W   = 12;
    localparam int DEF_SCAN_DIV   = 1;

    // Field order inside one digit's three-field group, counted from the LSB
    localparam int RED   = 2;
    localparam int GRN   = 1;
    localparam int ANODE = 0;

    function automatic int frame_w(input int num_digits, input int field_w);
        return num_digits * 3 * field_w;
    endfunction

    function automatic int field_lsb(input int digit, input int field, input int field_w);
        return (digit * 3 + field) * field_w;
    endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// rtl/led_scan_driver_if.sv - MCU serial/latch/brightness pins of led_scan_driver
interface led_scan_driver_if;
    logic ser_clk;
    logic ser_data;
    logic latch;
    logic pwm_ld;

    modport master (output ser_clk, output ser_data, output latch, output pwm_ld);
    modport slave  (input  ser_clk, input  ser_data, input  latch, input  pwm_ld);
endinterface

// File: rtl/led_scan_sync_edge.sv
// rtl/led_scan_sync_edge.sv - 2-flop synchroniser with rising-edge pulse
module led_scan_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);
    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
endmodule

// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - serial-loaded multiplexed bi-colour LED digit driver; LED_SCAN_BLANK_EN adds anti-ghost blanking
module led_scan_driver
    import led_scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SEGS       = DEF_SEGS,
    parameter int LEDS       = DEF_LEDS,
    parameter int FIELD_W    = DEF_FIELD_W,
    parameter int BRIGHT_W   = DEF_BRIGHT_W,
    parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    led_scan_driver_if.slave                     mcu,
    output logic [NUM_DIGITS*(2*SEGS+LEDS)-1:0]  digit_o,
    output logic                                 heartbeat,
    output logic                                 frame_err
);
    localparam int FRAME_W = frame_w(NUM_DIGITS, FIELD_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int DIG_W   = 2 * SEGS + LEDS;
    localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic sclk_rise, latch_rise, pwm_rise, sdata;
    logic sclk_level_unused, latch_level_unused, pwm_level_unused, sdata_rise_unused;

    led_scan_sync_edge u_sync_sclk  (.clk(clk), .rst_n(rst_n), .async_i(mcu.ser_clk),
                                     .level_o(sclk_level_unused),  .rise_o(sclk_rise));
    led_scan_sync_edge u_sync_sdata (.clk(clk), .rst_n(rst_n), .async_i(mcu.ser_data),
                                     .level_o(sdata),              .rise_o(sdata_rise_unused));
    led_scan_sync_edge u_sync_latch (.clk(clk), .rst_n(rst_n), .async_i(mcu.latch),
                                     .level_o(latch_level_unused), .rise_o(latch_rise));
    led_scan_sync_edge u_sync_pwm   (.clk(clk), .rst_n(rst_n), .async_i(mcu.pwm_ld),
                                     .level_o(pwm_level_unused),   .rise_o(pwm_rise));

    logic [FRAME_W-1:0]                    shift_q, shift_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][SEGS-1:0]       red_q, red_d, grn_q, grn_d;
    logic [NUM_DIGITS-1:0][LEDS-1:0]       anode_q, anode_d;
    logic [BRIGHT_W-1:0]                   bright_q, bright_d, pwm_q, pwm_d;
    logic                                  err_q, err_d;
    logic [PRE_W-1:0]                      presc_q, presc_d;
    logic [LEDS-1:0]                       led_q, led_d;
    logic [SEGS-1:0]                       seg_q, seg_d;
    logic [NUM_DIGITS*DIG_W-1:0]           digit_q, digit_d;
    logic                                  hb_q, oe, step, blank;

    // Shift happens before latch/pwm_ld so a coincident latch sees the updated count and data
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        red_d    = red_q;
        grn_d    = grn_q;
        anode_d  = anode_q;
        bright_d = bright_q;
        err_d    = err_q;
        if (sclk_rise) begin
            shift_d = {shift_q[FRAME_W-2:0], sdata};
            if (cnt_q != CNT_W'(FRAME_W + 1))
                cnt_d = cnt_q + CNT_W'(1);
        end
        if (pwm_rise) begin
            bright_d = shift_d[BRIGHT_W-1:0];
            if (cnt_d == '0)
                err_d = 1'b0;
        end
        if (latch_rise) begin
            if (cnt_d == CNT_W'(FRAME_W)) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    red_d[d]   = shift_d[field_lsb(d, RED,   FIELD_W) +: SEGS];
                    grn_d[d]   = shift_d[field_lsb(d, GRN,   FIELD_W) +: SEGS];
                    anode_d[d] = shift_d[field_lsb(d, ANODE, FIELD_W) +: LEDS];
                end
            end else begin
                err_d = 1'b1;
            end
            cnt_d = '0;
        end
    end

    always_comb begin
        step    = (presc_q == PRE_W'(SCAN_DIV - 1));
        presc_d = step ? '0 : presc_q + PRE_W'(1);
        led_d   = led_q;
        seg_d   = seg_q;
        if (step) begin
            led_d = {led_q[LEDS-2:0], led_q[LEDS-1]};
            if (led_q[LEDS-1])
                seg_d = {seg_q[SEGS-2:0], seg_q[SEGS-1]};
        end
        pwm_d = pwm_q + BRIGHT_W'(1);
        oe    = (pwm_q < bright_q);
        digit_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++)
            digit_d[d*DIG_W +: DIG_W] = {red_q[d] & seg_q, grn_q[d] & seg_q, anode_q[d] & led_q};
        if (!oe || blank)
            digit_d = '0;
    end

`ifdef LED_SCAN_BLANK_EN
    logic step_q;

    if (SCAN_DIV < 2) begin : g_div_check
        $error("LED_SCAN_BLANK_EN requires SCAN_DIV >= 2");
    end

    // Blank the first clock after each step so the old position never ghosts into the new one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
    assign blank = step_q;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            red_q    <= '0;
            grn_q    <= '0;
            anode_q  <= '0;
            bright_q <= '0;
            err_q    <= 1'b0;
            presc_q  <= '0;
            led_q    <= LEDS'(1);
            seg_q    <= SEGS'(1);
            pwm_q    <= '0;
            digit_q  <= '0;
            hb_q     <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            red_q    <= red_d;
            grn_q    <= grn_d;
            anode_q  <= anode_d;
            bright_q <= bright_d;
            err_q    <= err_d;
            presc_q  <= presc_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
            pwm_q    <= pwm_d;
            digit_q  <= digit_d;
            hb_q     <= oe;
        end
    end

    assign digit_o   = digit_q;
    assign heartbeat = hb_q;
    assign frame_err = err_q;
endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Parametrised multiplexed driver for N bi-colour seven-segment digits. Each segment is built from several LEDs.
- A microcontroller shifts in a serial frame and commits it with a latch pulse. It loads brightness with a separate pulse.
- The block then scans segment × LED positions autonomously and gates the outputs with a PWM.
- Sits between the MCU serial pins and the digit output pins.
- Successor features: arbitrary digit/segment/LED counts, a single synchronous clock domain, frame-length checking, programmable scan rate.

Parameters:
- NUM_DIGITS, 4, number of digits driven.
- SEGS, 7, segments per digit; one colour field width.
- LEDS, 7, LED positions per segment; anode field width.
- FIELD_W, 8, serial bits per field; must be ≥ max(SEGS, LEDS); the low bits are used, the MSB padding is discarded.
- BRIGHT_W, 12, PWM counter and brightness width.
- SCAN_DIV, 1, system clocks per scan step; must be ≥ 1.

Ports:
- clk  in  1  system clock (internal oscillator).
- rst_n  in  1  asynchronous active-low reset.
- ser_clk  in  1  MCU serial clock, async; sampled on its rising edge.
- ser_data  in  1  MCU serial data, async.
- latch  in  1  MCU frame commit, async; acts on its rising edge.
- pwm_ld  in  1  MCU brightness load, async; acts on its rising edge.
- digit_o  out  NUM_DIGITS*(2*SEGS+LEDS)  per digit d, MSB→LSB: {red&seg, grn&seg, anode&led}; digit 0 in the LSBs.
- heartbeat  out  1  copy of the PWM enable.
- frame_err  out  1  sticky; set when a latch arrives with a bad bit count.

Behaviour:
- Reset values: all registers clear, digit_o = 0, heartbeat = 0, frame_err = 0, bright = 0 (display dark), seg_sel = led_sel = one-hot bit 0.
- Input capture
  - ser_clk, ser_data, latch and pwm_ld each pass through a 2-flop synchroniser, then a rising-edge detect.
  - Input-to-action latency is 3 clk cycles.
- Shift register
  - Width FRAME_W = NUM_DIGITS*3*FIELD_W.
  - On each ser_clk edge: shift left by one, LSB takes ser_data.
  - A bit counter saturates at FRAME_W+1.
- Frame layout
  - Per digit the order is red, grn, anode fields; the last digit is sent first, so digit 0's anode field ends in the LSBs.
  - Example, NUM_DIGITS=4, FIELD_W=8: red4=[94:88], grn4=[86:80], ledA4=[78:72] … ledA1=[6:0].
- Latch edge
  - If bit count == FRAME_W: copy the fields into the active registers.
  - Otherwise: keep the active registers and set frame_err.
  - The bit count clears on every latch edge.
  - If a ser_clk edge and a latch edge occur in the same cycle, the shift happens first, the latch sees the updated count and data, and the count then clears.
- pwm_ld edge: bright ← shift[BRIGHT_W-1:0]. The bit count is not checked and not cleared. frame_err clears on pwm_ld only if the count is 0, so the MCU can clear the error with a bare pwm_ld pulse.
- Scan
  - A prescaler counts 0..SCAN_DIV-1; on wrap it issues a step.
  - Step: led_sel rotates left one-hot; on wrap from bit LEDS-1, led_sel returns to bit 0 and seg_sel rotates left, wrapping at bit SEGS-1.
  - Full scan takes SEGS*LEDS*SCAN_DIV clocks.
- PWM
  - A free-running BRIGHT_W counter wraps modulo 2^BRIGHT_W.
  - oe = (pwm_cnt < bright). bright=0 gives always off; bright=max gives on for all but one count.
- Output
  - Registered. digit_o ← oe ? {red&seg_sel, grn&seg_sel, anode&led_sel} for every digit : 0.
  - heartbeat ← oe in the same cycle.
  - Latency from the scan/PWM state to the pins is 1 clk.
- Reset asserted mid-frame: the partial frame is lost and the outputs go 0 immediately (asynchronously).

Optional Feature:
- Macro: LED_SCAN_BLANK_EN.
- Defined: for one clk after each scan step, digit_o is forced to 0 (anti-ghosting), and the step period is unchanged. SCAN_DIV must be ≥ 2; this is checked at elaboration.
- Undefined: no blanking; outputs follow the scan state directly.

Decomposition:
- Package led_scan_pkg: FRAME_W and per-field offset functions, the field-index constants (RED=2, GRN=1, ANODE=0), and the default parameter values.
- One sub-module: led_scan_sync_edge, a 2-flop synchroniser plus rising-edge pulse with async active-low reset. It is instantiated four times.

Test Plan:
- Reset, then read outputs without any load:
  - Check: digit_o = 0, heartbeat = 0, frame_err = 0 at all times.
- Shift 96 bits (digit1 red=7'h01, grn=0, anode=7'h7F; other digits 0), latch, then pwm_ld with bright=12'hFFF:
  - Check: digit_o[20:0] shows anode bits cycling one-hot through all 7 positions while seg_sel=bit 0, and red bit 0 is high during that interval.
- Shift 95 bits, then latch:
  - Check: active registers unchanged and frame_err = 1.
  - Then pwm_ld with count 0: check frame_err = 0.
- bright=12'h800, observe 4096 clocks:
  - Check: heartbeat is high for exactly 2048 cycles per period.
  - bright=0: check heartbeat never high.
- SCAN_DIV=3, observe LED positions:
  - Check: each LED position is held 3 clocks and seg_sel advances every 21 clocks.
  - With LED_SCAN_BLANK_EN: check the first clock of each 3 is 0.
- Assert rst_n mid-shift (after 40 bits), release, then send a full frame:
  - Check: outputs went 0 immediately, and the new frame latches cleanly with frame_err = 0.
